// File: rtl/i2c_slave_rx_ctrl_pkg.sv
// Shared definitions for the I2C slave receive controller: FSM encoding,
// ACK/NACK bit values and the address width.
package i2c_slave_rx_ctrl_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_ADDR  = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK_DATA  = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_e;

endpackage

// File: rtl/i2c_slave_rx_ctrl_shift.sv
// MSB-first 8-bit shift register. byte_o presents the byte that completes
// when the current bit is the last one (shreg[6:0] plus the live bit).
module i2c_rx_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic       bit_i,
  output logic [7:0] byte_o
);

  logic [7:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = 8'h00;
    end else if (ld_i) begin
      shreg_d = {shreg_q[6:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 8'h00;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign byte_o = {shreg_q[6:0], bit_i};

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// I2C slave receive controller: drives the read stage, matches the address,
// requests ACK/NACK bits and buffers write-data bytes for the user side.
module i2c_slave_rx_ctrl
  import i2c_slave_rx_ctrl_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       rd_en_o,
  output logic       is_byte_o,
  input  logic       rd_ld_i,
  input  logic       rd_bit_i,
  input  logic       rd_finish_i,
  input  logic       get_start_i,
  input  logic       get_stop_i,
  input  logic       rd_err_i,
  output logic       ack_req_o,
  output logic       ack_value_o,
  input  logic       ack_done_i,
  output logic       tx_req_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       addr_match_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       bus_err_o,
  output state_e     state_o
);

  // User handshake: a byte transfers in any cycle where rx_valid_o && rx_ready_i;
  // rx_data_o is stable while rx_valid_o is high and no transfer happens.

  state_e     state_q, state_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_match_q, addr_match_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       ack_value_q, ack_value_d;
  logic       tx_req_q, tx_req_d;
  logic       overflow_q, overflow_d;
  logic       bus_err_q, bus_err_d;
  logic       sh_clr, sh_ld;
  logic [7:0] rx_byte;

  assign sh_ld = rd_ld_i && !sh_clr && (state_q == ST_ADDR || state_q == ST_DATA);

  i2c_rx_shift u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (sh_clr),
    .ld_i   (sh_ld),
    .bit_i  (rd_bit_i),
    .byte_o (rx_byte)
  );

  always_comb begin
    state_d      = state_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    rw_d         = rw_q;
    ack_value_d  = ack_value_q;
    tx_req_d     = 1'b0;
    overflow_d   = 1'b0;
    bus_err_d    = 1'b0;
    sh_clr       = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    if (state_q != ST_IDLE && get_stop_i) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
    end else if (get_start_i &&
                 (state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_WAIT_STOP)) begin
      state_d      = ST_ADDR;
      addr_match_d = 1'b0;
      sh_clr       = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (get_start_i) begin
            state_d = ST_ADDR;
            busy_d  = 1'b1;
            sh_clr  = 1'b1;
          end
        end
        ST_ADDR: begin
          if (rd_err_i) begin
            bus_err_d = 1'b1;
            state_d   = ST_WAIT_STOP;
          end else if (rd_finish_i) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              rw_d         = rx_byte[0];
              addr_match_d = 1'b1;
              ack_value_d  = ACK;
              state_d      = ST_ACK_ADDR;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (ack_done_i) begin
            if (rw_q) begin
              tx_req_d = 1'b1;
              state_d  = ST_WAIT_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rd_err_i) begin
            bus_err_d = 1'b1;
            state_d   = ST_WAIT_STOP;
          end else if (rd_finish_i) begin
            // A pop in this same cycle frees the buffer for the new byte.
            if (rx_valid_q && !rx_ready_i) begin
              overflow_d  = 1'b1;
              ack_value_d = NACK;
            end else begin
              rx_data_d   = rx_byte;
              rx_valid_d  = 1'b1;
              ack_value_d = ACK;
            end
            state_d = ST_ACK_DATA;
          end
        end
        ST_ACK_DATA: begin
          if (ack_done_i) begin
            state_d = (ack_value_q == NACK) ? ST_WAIT_STOP : ST_DATA;
          end
        end
        ST_WAIT_STOP: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      rw_q         <= 1'b0;
      ack_value_q  <= ACK;
      tx_req_q     <= 1'b0;
      overflow_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
      ack_value_q  <= ack_value_d;
      tx_req_q     <= tx_req_d;
      overflow_q   <= overflow_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign rd_en_o      = !(state_q == ST_ACK_ADDR || state_q == ST_ACK_DATA);
  assign ack_req_o    = (state_q == ST_ACK_ADDR || state_q == ST_ACK_DATA);
  assign is_byte_o    = 1'b1;
  assign ack_value_o  = ack_value_q;
  assign tx_req_o     = tx_req_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign addr_match_o = addr_match_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign bus_err_o    = bus_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Directed bench for i2c_slave_rx_ctrl: address match/mismatch, data buffering,
// overflow, read handoff, repeated start, bus error and async reset.
module tb_i2c_slave_rx_ctrl;
  import i2c_slave_rx_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_ld = 1'b0, rd_bit = 1'b0, rd_finish = 1'b0;
  logic       get_start = 1'b0, get_stop = 1'b0, rd_err = 1'b0;
  logic       ack_done = 1'b0, rx_ready = 1'b0;
  logic       rd_en, is_byte, ack_req, ack_value, tx_req;
  logic [7:0] rx_data;
  logic       rx_valid, addr_match, busy, overflow, bus_err;
  state_e     state;

  int tests = 0;
  int failed = 0;

  i2c_slave_rx_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en_o      (rd_en),
    .is_byte_o    (is_byte),
    .rd_ld_i      (rd_ld),
    .rd_bit_i     (rd_bit),
    .rd_finish_i  (rd_finish),
    .get_start_i  (get_start),
    .get_stop_i   (get_stop),
    .rd_err_i     (rd_err),
    .ack_req_o    (ack_req),
    .ack_value_o  (ack_value),
    .ack_done_i   (ack_done),
    .tx_req_o     (tx_req),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .addr_match_o (addr_match),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .bus_err_o    (bus_err),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    get_start = 1'b1; step(); get_start = 1'b0;
  endtask

  task automatic pulse_stop();
    get_stop = 1'b1; step(); get_stop = 1'b0;
  endtask

  task automatic pulse_ack_done();
    ack_done = 1'b1; step(); ack_done = 1'b0;
  endtask

  // Shifts n bits MSB-first; rd_finish marks the 8th bit. pop_last pops the
  // user buffer in the same cycle as the last bit.
  task automatic send_bits(input logic [7:0] b, input int n, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      rd_ld     = 1'b1;
      rd_bit    = b[7-i];
      rd_finish = (i == 7);
      rx_ready  = pop_last && (i == n - 1);
      step();
      rd_ld = 1'b0; rd_finish = 1'b0; rx_ready = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"},      state,      ST_IDLE);
    chk({pfx, "_rd_en"},      rd_en,      1);
    chk({pfx, "_is_byte"},    is_byte,    1);
    chk({pfx, "_ack_req"},    ack_req,    0);
    chk({pfx, "_ack_value"},  ack_value,  0);
    chk({pfx, "_tx_req"},     tx_req,     0);
    chk({pfx, "_rx_data"},    rx_data,    8'h00);
    chk({pfx, "_rx_valid"},   rx_valid,   0);
    chk({pfx, "_addr_match"}, addr_match, 0);
    chk({pfx, "_busy"},       busy,       0);
    chk({pfx, "_overflow"},   overflow,   0);
    chk({pfx, "_bus_err"},    bus_err,    0);
  endtask

  initial begin
    // Reset
    step(); step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Matched write address, one data byte, STOP
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_state_addr", state, ST_ADDR);
    send_bits(8'hA0, 8, 0);
    chk("t1_ack_req", ack_req, 1);
    chk("t1_ack_value", ack_value, 0);
    chk("t1_addr_match", addr_match, 1);
    chk("t1_rd_en_ack", rd_en, 0);
    chk("t1_state_ackaddr", state, ST_ACK_ADDR);
    pulse_ack_done();
    chk("t1_state_data", state, ST_DATA);
    chk("t1_rd_en_data", rd_en, 1);
    chk("t1_tx_req", tx_req, 0);
    send_bits(8'h3C, 8, 0);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_ack_req_d", ack_req, 1);
    chk("t1_ack_value_d", ack_value, 0);
    pulse_ack_done();
    chk("t1_state_data2", state, ST_DATA);
    pulse_stop();
    chk("t1_busy_stop", busy, 0);
    chk("t1_state_idle", state, ST_IDLE);
    chk("t1_match_stop", addr_match, 0);
    chk("t1_rx_valid_persist", rx_valid, 1);
    chk("t1_rx_data_persist", rx_data, 8'h3C);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    chk("t1_pop", rx_valid, 0);

    // Address mismatch
    pulse_start();
    send_bits(8'hA2, 8, 0);
    chk("t2_state", state, ST_WAIT_STOP);
    chk("t2_ack_req", ack_req, 0);
    chk("t2_addr_match", addr_match, 0);
    send_bits(8'h55, 8, 0);
    chk("t2_still_wait", state, ST_WAIT_STOP);
    chk("t2_no_rx", rx_valid, 0);
    pulse_stop();
    chk("t2_idle", state, ST_IDLE);

    // Overflow with rx_ready held low, then pop-on-completion boundary
    pulse_start();
    send_bits(8'hA0, 8, 0);
    pulse_ack_done();
    send_bits(8'h11, 8, 0);
    chk("t3_rx_data1", rx_data, 8'h11);
    chk("t3_ack1", ack_value, 0);
    pulse_ack_done();
    send_bits(8'h22, 8, 0);
    chk("t3_overflow", overflow, 1);
    chk("t3_nack", ack_value, 1);
    chk("t3_ack_req", ack_req, 1);
    chk("t3_rx_data_kept", rx_data, 8'h11);
    chk("t3_state", state, ST_ACK_DATA);
    step();
    chk("t3_overflow_pulse", overflow, 0);
    pulse_ack_done();
    chk("t3_nack_wait", state, ST_WAIT_STOP);
    pulse_stop();
    pulse_start();
    send_bits(8'hA0, 8, 0);
    pulse_ack_done();
    send_bits(8'h33, 8, 1);
    chk("t3_pop_same_data", rx_data, 8'h33);
    chk("t3_pop_same_valid", rx_valid, 1);
    chk("t3_pop_same_ovf", overflow, 0);
    chk("t3_pop_same_ack", ack_value, 0);
    pulse_ack_done();
    pulse_stop();
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    chk("t3_pop", rx_valid, 0);

    // Read-direction address hands off with tx_req
    pulse_start();
    send_bits(8'hA1, 8, 0);
    chk("t4_ack_value", ack_value, 0);
    chk("t4_ack_req", ack_req, 1);
    pulse_ack_done();
    chk("t4_tx_req", tx_req, 1);
    chk("t4_state", state, ST_WAIT_STOP);
    step();
    chk("t4_tx_req_pulse", tx_req, 0);
    pulse_stop();

    // Repeated START mid-DATA, rd_err mid-byte
    pulse_start();
    send_bits(8'hA0, 8, 0);
    pulse_ack_done();
    send_bits(8'hF0, 4, 0);
    pulse_start();
    chk("t5_rs_state", state, ST_ADDR);
    chk("t5_rs_match", addr_match, 0);
    chk("t5_rs_busy", busy, 1);
    send_bits(8'hA0, 8, 0);
    chk("t5_readdr", state, ST_ACK_ADDR);
    pulse_ack_done();
    send_bits(8'h0F, 3, 0);
    rd_err = 1'b1; step(); rd_err = 1'b0;
    chk("t5_bus_err", bus_err, 1);
    chk("t5_err_state", state, ST_WAIT_STOP);
    chk("t5_err_no_rx", rx_valid, 0);
    rd_err = 1'b1; step(); rd_err = 1'b0;
    chk("t5_err_ignored", bus_err, 0);
    // STOP outranks START
    get_start = 1'b1; get_stop = 1'b1; step(); get_start = 1'b0; get_stop = 1'b0;
    chk("t5_stop_prio", state, ST_IDLE);

    // Async reset mid-ACK
    pulse_start();
    send_bits(8'hA0, 8, 0);
    chk("t6_in_ack", ack_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    step();
    rst_n = 1'b1;
    step();
    chk("t6_after_idle", state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
